// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch T0-T2, decode T3, execute T4-T6, HALT.
// Optional MULDIV_EN adds mul/div opcodes that write LO/HI through T5/T6.
module control_sequencer (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic        mem_ready,
  input  logic [31:0] ir,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        PCin,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        HIin,
  output logic        LOin,
  output logic [15:0] reg_out,
  output logic [15:0] reg_in,
  output logic [4:0]  opcode,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [3:0] {
    IDLE, T0, T1, T2, T3, T4, T5, T6, HALT
  } state_t;

  state_t state_q;

  logic [4:0] opc;
  logic [3:0] ra, rb, rc;
  logic       md_op, alu_op, halt_op;
  logic       ir_unused;

  assign opc       = ir[31:27];
  assign ra        = ir[26:23];
  assign rb        = ir[22:19];
  assign rc        = ir[18:15];
  assign ir_unused = ^ir[14:0];
  assign halt_op   = (opc == 5'b11011);

`ifdef MULDIV_EN
  assign md_op = (opc == 5'b01111) || (opc == 5'b10000);
`else
  assign md_op = 1'b0;
`endif

  assign alu_op = (opc <= 5'd12) || md_op;

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: if (run) state_q <= T0;
        T0:   state_q <= T1;
        T1:   if (mem_ready) state_q <= T2;
        T2:   state_q <= T3;
        T3: begin
          if (alu_op)       state_q <= T4;
          else if (halt_op) state_q <= HALT;
          else              state_q <= run ? T0 : IDLE;
        end
        T4:   state_q <= T5;
        T5: begin
          if (md_op) state_q <= T6;
          else       state_q <= run ? T0 : IDLE;
        end
        T6:   state_q <= run ? T0 : IDLE;
        HALT: state_q <= HALT;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    PCout    = 1'b0;
    MARin    = 1'b0;
    IncPC    = 1'b0;
    Zin      = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    PCin     = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    reg_out  = '0;
    reg_in   = '0;
    opcode   = '0;
    halted   = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      T3: begin
        if (alu_op) begin
          reg_out[rb] = 1'b1;
          Yin         = 1'b1;
        end else if (!halt_op) begin
          illegal = 1'b1;
        end
      end
      T4: begin
        reg_out[rc] = 1'b1;
        Zin         = 1'b1;
        opcode      = opc;
      end
      T5: begin
        Zlowout = 1'b1;
        // mul/div result goes to LO, never to a GPR
        if (md_op) LOin = 1'b1;
        else       reg_in[ra] = 1'b1;
      end
      T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
      end
      HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 clock  input  1  sole clock; all state updates on rising edge.
REQ-002 clear  input  1  synchronous, active-low reset; sampled on rising edge of clock.
REQ-003 run  input  1  high permits fetch of next instruction.
REQ-004 mem_ready  input  1  memory read data valid on Mdatain this cycle.
REQ-005 ir  input  32  datapath IR contents: opcode ir[31:27], Ra ir[26:23], Rb ir[22:19], Rc ir[18:15].
REQ-006 PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read, MDRin, MDRout, IRin, Yin, HIin, LOin  output  1 each  datapath strobes.
REQ-007 reg_out  output  16  one-hot register-to-bus enable, bit n = Rnout.
REQ-008 reg_in  output  16  one-hot bus-to-register load, bit n = Rnin.
REQ-009 opcode  output  5  ALU operation select.
REQ-010 halted  output  1  high while in HALT.
REQ-011 illegal  output  1  one-cycle pulse on undecodable opcode.

Function
REQ-012 States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT; all outputs are a pure function of state and ir (Moore); unlisted outputs 0 in every state.
REQ-013 IDLE: all outputs 0; run=1 -> T0, else stay.
REQ-014 T0: PCout, MARin, IncPC, Zin = 1; -> T1.
REQ-015 T1: Zlowout, PCin, Read, MDRin = 1 every T1 cycle; mem_ready=1 -> T2, else stay in T1 with strobes held (wait states unbounded).
REQ-016 T2: MDRout, IRin = 1; -> T3.
REQ-017 T3 decodes ir[31:27] (IR valid after T2 edge): ALU class 00000-01100 -> reg_out[Rb]=1, Yin=1, -> T4; 11011 (halt) -> HALT, no strobes; any other opcode -> illegal=1, no strobes, -> T0 if run=1 else IDLE.
REQ-018 T4: reg_out[Rc]=1, Zin=1, opcode=ir[31:27]; -> T5.
REQ-019 T5 (ALU class): Zlowout=1, reg_in[Ra]=1; -> T0 if run=1, else IDLE.
REQ-020 opcode output = 5'b00000 in every state except T4.
REQ-021 reg_out and reg_in at most one bit set in any cycle; never both set for same index in same cycle.
REQ-022 Ra=Rb=Rc permitted; no special handling; R0 writable.
REQ-023 Zero-wait instruction latency: 6 cycles T0..T5; each mem_ready=0 cycle in T1 adds one.
REQ-024 HALT: halted=1, all strobes 0; exits only via clear=0.
REQ-025 run sampled only in IDLE and at instruction end; deassertion mid-instruction does not abort it.

Reset
REQ-026 clear=0 at rising edge -> IDLE regardless of state (including T1 wait and HALT); after that edge all outputs 0, halted=0, illegal=0.
REQ-027 clear=0 held keeps IDLE irrespective of run and mem_ready.

Configuration
REQ-028 Macro MULDIV_EN defined: opcodes 01111 (mul) and 10000 (div) decoded in T3 as ALU class; T5 = Zlowout, LOin -> T6; T6 = Zhighout, HIin -> T0/IDLE per run; no reg_in asserted; latency 7 cycles.
REQ-029 MULDIV_EN undefined: 01111 and 10000 treated as illegal per REQ-017; T6 unreachable.

Verification
REQ-030 clear=0 one cycle, run=1, mem_ready=1, ir=0x2A2B8000 (AND, Ra=4, Rb=5, Rc=7) -> states T0..T5 in 6 cycles; T3 reg_out=0x0020+Yin; T4 reg_out=0x0080, opcode=00101, Zin; T5 reg_in=0x0010, Zlowout.
REQ-031 Same as REQ-030 with mem_ready low 3 cycles in T1 -> T1 lasts 4 cycles, Read/MDRin/PCin held, T2 follows first mem_ready=1.
REQ-032 ir opcode=11011 -> HALT after T3, halted=1, no reg_in; run toggling ignored; clear=0 -> IDLE, halted=0.
REQ-033 ir opcode=11111 -> illegal pulse exactly one cycle in T3, no reg_in/Zin; next cycle T0 with run=1.
REQ-034 clear=0 asserted in T4 -> next cycle IDLE, all outputs 0, Zin and opcode 0.
REQ-035 MULDIV_EN defined, opcode 01111 -> T5 LOin+Zlowout, T6 HIin+Zhighout, reg_in=0 throughout; undefined -> illegal pulse.
